user_id_reader: RTL and testbench
=================================

# user_id_reader

Sequencing and arbitration controller for the user project ID / mask revision word. It sits between the constant-cell ID block and its two consumers: the housekeeping SPI (requester 0) and the management CPU bus (requester 1). After reset it waits for the tie-cell outputs to settle, then captures the 32-bit ID with a double-sample stability check. It then serves byte reads to both requesters through a round-robin req/ack handshake, so each consumer reads a registered, glitch-free copy instead of the raw cell outputs.

## Interface

Parameters:
- SETTLE_CYCLES, default 8: cycles after reset release before the first capture; legal range 1–255.
- RECHECK_LOG2, default 16: log2 of the idle re-capture period; used only when USER_ID_RECHECK_EN is defined.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- mask_rev  in  32  raw ID word from the constant-cell block.
- req  in  2  read requests; bit 0 = SPI, bit 1 = CPU. Level-held until ack.
- addr0  in  2  byte select for requester 0.
- addr1  in  2  byte select for requester 1.
- ack  out  2  one-cycle grant/complete pulse per requester.
- rdata  out  8  selected byte; valid only while an ack bit is high.
- id_word  out  32  captured ID.
- id_valid  out  1  high once the capture is confirmed stable.
- retry_cnt  out  4  saturating count of capture mismatches.
- id_error  out  1  sticky re-check mismatch flag.

## Operation

- FSM states: SETTLE, CAP_A, CAP_B, IDLE, SERVE.
- SETTLE: counter counts SETTLE_CYCLES cycles, then moves to CAP_A.
- CAP_A: shadow_a <= mask_rev.
- CAP_B: compare mask_rev with shadow_a.
  - Equal: id_word <= mask_rev, id_valid <= 1, go to IDLE.
  - Unequal: retry_cnt increments (saturates at 15), return to CAP_A.
- IDLE:
  - No req: stay in IDLE.
  - Any req: arbiter picks grant g, latches g and its addr, goes to SERVE.
- SERVE: ack[g] = 1, rdata = id_word[8*addr+7 : 8*addr], return to IDLE; rr pointer <= g.
- Round-robin: the requester granted last has lowest priority on the next arbitration. After reset requester 0 has priority.
- Requests raised before id_valid are held off. They are not dropped; they are served once IDLE is reached.
- A requester that keeps req high after its ack is treated as a new request. If both requesters are asserting, they alternate.
- addr is sampled in IDLE at arbitration; later changes do not affect that transfer.
- Reset mid-operation: any pending transfer is abandoned with no ack, and the FSM restarts in SETTLE.

## Timing

- Reset values: ack=0, rdata=0, id_word=0, id_valid=0, retry_cnt=0, id_error=0; FSM in SETTLE; rr pointer favours requester 0.
- With a stable input, id_valid rises on the (SETTLE_CYCLES+2)-th rising edge after resetn deasserts.
- Each mismatch adds 2 cycles.
- Request latency: req sampled high in IDLE → ack on the next cycle (SERVE).
- Peak throughput: one ack every 2 cycles.
- At most one ack bit is high in any cycle. rdata returns to 0 when no ack is high.
- id_word and id_valid are stable after capture. They change only on reset.

## Configuration

- USER_ID_RECHECK_EN defined:
  - A RECHECK_LOG2-bit free-running counter runs in IDLE.
  - On wrap, if req==0, the FSM performs one re-capture (CAP_A/CAP_B equivalent) without touching id_word or id_valid.
  - If a req is pending at wrap, the re-check is deferred to the first request-free IDLE cycle.
  - A mismatch between the new sample and id_word sets id_error (sticky until reset).
  - Requests arriving during a re-check wait at most 2 cycles.
- USER_ID_RECHECK_EN undefined: no counter and no re-check logic; id_error is tied to 0.

## Test plan

- Reset release, mask_rev=32'hA5C3_0F12, SETTLE_CYCLES=8 → id_valid=1 at edge 10, id_word=32'hA5C3_0F12, retry_cnt=0.
- Toggle mask_rev between CAP_A and CAP_B twice, then hold 32'h1234_5678 → retry_cnt=2, id_valid at edge 14, id_word=32'h1234_5678.
- After id_valid, req=2'b01 with addr0=3 → ack=2'b01 the next cycle, rdata=8'hA5; req dropped → no further ack.
- req=2'b11 held for 8 cycles, addr0=0, addr1=1 → acks alternate 01,10,01,10 every 2 cycles; rdata alternates 8'h12 and 8'h0F.
- req1 asserted at cycle 3 after reset → held off, served with ack=2'b10 one cycle after id_valid; resetn pulsed low while in SERVE → ack=0, id_valid=0, capture restarts.
- With USER_ID_RECHECK_EN and RECHECK_LOG2=4: change mask_rev after capture → id_error=1 within 18 idle cycles, id_word unchanged. Without the macro → id_error stays 0.

Source files
------------

// File: rtl/user_id_if.sv
// Read handshake between the ID consumers (SPI = bit 0, CPU = bit 1) and user_id_reader.
interface user_id_if;
  logic [1:0] req;
  logic [1:0] addr0;
  logic [1:0] addr1;
  logic [1:0] ack;
  logic [7:0] rdata;

  modport master (output req, addr0, addr1, input ack, rdata);
  modport slave  (input req, addr0, addr1, output ack, rdata);
endinterface

// File: rtl/user_id_reader.sv
// Settles, double-sample captures the user ID word and serves round-robin byte reads.
// Optional periodic idle re-check of the ID cells: define USER_ID_RECHECK_EN.
module user_id_reader #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned RECHECK_LOG2  = 16
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [31:0] mask_rev_i,
  user_id_if.slave    bus,
  output logic [31:0] id_word_o,
  output logic        id_valid_o,
  output logic [3:0]  retry_cnt_o,
  output logic        id_error_o
);

  // state  | meaning
  // SETTLE | waiting for tie-cell outputs to settle
  // CAP_A  | first sample into shadow
  // CAP_B  | second sample, compare against shadow (or id_word on re-check)
  // IDLE   | arbitrate pending requests
  // SERVE  | ack + byte driven for one cycle
  localparam logic [2:0] S_SETTLE = 3'd0;
  localparam logic [2:0] S_CAP_A  = 3'd1;
  localparam logic [2:0] S_CAP_B  = 3'd2;
  localparam logic [2:0] S_IDLE   = 3'd3;
  localparam logic [2:0] S_SERVE  = 3'd4;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
      RECHECK_LOG2 < 2 || RECHECK_LOG2 > 31) begin : g_param_chk
    $error("user_id_reader: parameter out of range");
  end

  logic [2:0]  state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] id_word_q, id_word_d;
  logic        id_valid_q, id_valid_d;
  logic [3:0]  retry_q, retry_d;
  logic [1:0]  ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        gnt_q, gnt_d;
  logic        rr_q, rr_d;
  logic        gnt_pick;
  logic [1:0]  addr_pick;
  logic        rchk_start;
  logic        rchk_mode;

  // rr_q holds the last granted requester; reset value 1 hands priority to requester 0.
  always_comb begin
    if (bus.req == 2'b11) gnt_pick = ~rr_q;
    else                  gnt_pick = bus.req[1];
    addr_pick = gnt_pick ? bus.addr1 : bus.addr0;
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    shadow_d   = shadow_q;
    id_word_d  = id_word_q;
    id_valid_d = id_valid_q;
    retry_d    = retry_q;
    ack_d      = 2'b00;
    rdata_d    = 8'h00;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    case (state_q)
      S_SETTLE: begin
        if (settle_q == 8'd0) state_d = S_CAP_A;
        else                  settle_d = settle_q - 8'd1;
      end
      S_CAP_A: begin
        shadow_d = mask_rev_i;
        state_d  = S_CAP_B;
      end
      S_CAP_B: begin
        if (rchk_mode) begin
          state_d = S_IDLE;
        end else if (mask_rev_i == shadow_q) begin
          id_word_d  = mask_rev_i;
          id_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
          state_d = S_CAP_A;
        end
      end
      S_IDLE: begin
        if (rchk_start) begin
          state_d = S_CAP_A;
        end else if (|bus.req) begin
          gnt_d   = gnt_pick;
          ack_d   = gnt_pick ? 2'b10 : 2'b01;
          rdata_d = id_word_q[{addr_pick, 3'b000} +: 8];
          state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        rr_d    = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_SETTLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= S_SETTLE;
      settle_q   <= 8'(SETTLE_CYCLES - 1);
      shadow_q   <= 32'h0;
      id_word_q  <= 32'h0;
      id_valid_q <= 1'b0;
      retry_q    <= 4'h0;
      ack_q      <= 2'b00;
      rdata_q    <= 8'h00;
      gnt_q      <= 1'b0;
      rr_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      shadow_q   <= shadow_d;
      id_word_q  <= id_word_d;
      id_valid_q <= id_valid_d;
      retry_q    <= retry_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
    end
  end

`ifdef USER_ID_RECHECK_EN
  logic [RECHECK_LOG2-1:0] rchk_cnt_q, rchk_cnt_d;
  logic                    rchk_pend_q, rchk_pend_d;
  logic                    rchk_act_q, rchk_act_d;
  logic                    id_error_q, id_error_d;

  // A wrap seen while a request is pending is remembered and run on the next quiet IDLE cycle.
  assign rchk_start = (state_q == S_IDLE) && (bus.req == 2'b00) &&
                      (rchk_pend_q || (&rchk_cnt_q));
  assign rchk_mode  = rchk_act_q;

  always_comb begin
    rchk_cnt_d  = rchk_cnt_q;
    rchk_pend_d = rchk_pend_q;
    rchk_act_d  = rchk_act_q;
    id_error_d  = id_error_q;
    if (state_q == S_IDLE) begin
      rchk_cnt_d = rchk_cnt_q + 1'b1;
      if (rchk_start) begin
        rchk_pend_d = 1'b0;
        rchk_act_d  = 1'b1;
      end else if (&rchk_cnt_q) begin
        rchk_pend_d = 1'b1;
      end
    end
    if (state_q == S_CAP_B && rchk_act_q) begin
      rchk_act_d = 1'b0;
      if (shadow_q != id_word_q) id_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rchk_cnt_q  <= '0;
      rchk_pend_q <= 1'b0;
      rchk_act_q  <= 1'b0;
      id_error_q  <= 1'b0;
    end else begin
      rchk_cnt_q  <= rchk_cnt_d;
      rchk_pend_q <= rchk_pend_d;
      rchk_act_q  <= rchk_act_d;
      id_error_q  <= id_error_d;
    end
  end

  assign id_error_o = id_error_q;
`else
  assign rchk_start = 1'b0;
  assign rchk_mode  = 1'b0;
  assign id_error_o = 1'b0;
`endif

  assign bus.ack     = ack_q;
  assign bus.rdata   = rdata_q;
  assign id_word_o   = id_word_q;
  assign id_valid_o  = id_valid_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_user_id_reader.sv
// Scoreboard bench for user_id_reader: capture timing, retries, round-robin reads, reset abort.
module tb_user_id_reader;

  logic        clk;
  logic        resetn;
  logic [31:0] mask_rev;
  logic [1:0]  req;
  logic [1:0]  addr0;
  logic [1:0]  addr1;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic [31:0] id_word;
  logic        id_valid;
  logic [3:0]  retry_cnt;
  logic        id_error;

  int n_chk = 0;
  int n_err = 0;
  logic [9:0] sb_q[$];

  user_id_if bus_if ();
  assign bus_if.req   = req;
  assign bus_if.addr0 = addr0;
  assign bus_if.addr1 = addr1;
  assign ack          = bus_if.ack;
  assign rdata        = bus_if.rdata;

  user_id_reader #(.SETTLE_CYCLES(8), .RECHECK_LOG2(4)) dut (
    .clk_i      (clk),
    .resetn_i   (resetn),
    .mask_rev_i (mask_rev),
    .bus        (bus_if.slave),
    .id_word_o  (id_word),
    .id_valid_o (id_valid),
    .retry_cnt_o(retry_cnt),
    .id_error_o (id_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (ack !== 2'b00) begin
        if (sb_q.size() == 0) begin
          chk("ack_unexpected", {22'h0, ack, rdata}, 32'h0);
        end else begin
          logic [9:0] e;
          e = sb_q.pop_front();
          chk("sb_ack", {30'h0, ack}, {30'h0, e[9:8]});
          chk("sb_rdata", {24'h0, rdata}, {24'h0, e[7:0]});
        end
      end else if (rdata !== 8'h00) begin
        chk("rdata_idle", {24'h0, rdata}, 32'h0);
      end
      if (ack === 2'b11) chk("ack_onehot", {30'h0, ack}, 32'h1);
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    req    = 2'b00;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic capture_check(input int edge_n, input logic [31:0] exp_word,
                               input logic [3:0] exp_retry);
    for (int e = 1; e <= edge_n; e++) begin
      @(posedge clk);
      #1;
      if (e == edge_n - 1) chk("valid_early", {31'h0, id_valid}, 32'h0);
      if (e == edge_n) begin
        chk("valid_edge", {31'h0, id_valid}, 32'h1);
        chk("id_word", id_word, exp_word);
        chk("retry_cnt", {28'h0, retry_cnt}, {28'h0, exp_retry});
      end
    end
  endtask

  task automatic rd(input int r, input logic [1:0] a, input logic [7:0] exp);
    int lat;
    lat = 0;
    sb_q.push_back({(r == 1) ? 2'b10 : 2'b01, exp});
    if (r == 1) addr1 = a;
    else        addr0 = a;
    req[r] = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (ack == 2'b00 && lat < 6);
    req = 2'b00;
`ifdef USER_ID_RECHECK_EN
    chk("rd_lat_le3", {31'h0, lat <= 3}, 32'h1);
`else
    chk("rd_lat", lat, 1);
`endif
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack, cyc, first, last;
    resetn   = 1'b0;
    req      = 2'b00;
    addr0    = 2'd0;
    addr1    = 2'd0;
    mask_rev = 32'hA5C3_0F12;
    repeat (2) @(negedge clk);
    chk("rst_ack", {30'h0, ack}, 32'h0);
    chk("rst_rdata", {24'h0, rdata}, 32'h0);
    chk("rst_id_word", id_word, 32'h0);
    chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_retry", {28'h0, retry_cnt}, 32'h0);
    chk("rst_id_error", {31'h0, id_error}, 32'h0);
    resetn = 1'b1;
    capture_check(10, 32'hA5C3_0F12, 4'd0);

    @(negedge clk);
    rd(0, 2'd3, 8'hA5);
    rd(1, 2'd2, 8'hC3);

    // both requesters held: grants must alternate starting with requester 0
    sb_q.push_back({2'b01, 8'h12});
    sb_q.push_back({2'b10, 8'h0F});
    sb_q.push_back({2'b01, 8'h12});
    sb_q.push_back({2'b10, 8'h0F});
    addr0 = 2'd0;
    addr1 = 2'd1;
    req   = 2'b11;
    n_ack = 0; cyc = 0; first = 0; last = 0;
    while (n_ack < 4 && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ack != 2'b00) begin
        n_ack++;
        if (n_ack == 1) first = cyc;
        last = cyc;
      end
    end
    req = 2'b00;
    chk("alt_count", n_ack, 4);
    chk("alt_span", last - first, 6);
    repeat (4) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    mask_rev = 32'hDEAD_BEEF;
`ifdef USER_ID_RECHECK_EN
    cyc = 0;
    while (id_error !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("recheck_err", {31'h0, id_error}, 32'h1);
`else
    repeat (40) @(negedge clk);
    chk("no_recheck_err", {31'h0, id_error}, 32'h0);
`endif
    chk("word_kept", id_word, 32'hA5C3_0F12);
    chk("valid_kept", {31'h0, id_valid}, 32'h1);

    // mask flickers across two CAP_A/CAP_B pairs before settling
    mask_rev = 32'h1111_1111;
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk);
      #1;
      case (e)
        9:  mask_rev = 32'h2222_2222;
        11: mask_rev = 32'h3333_3333;
        12: mask_rev = 32'h1234_5678;
        13: chk("mm_valid_early", {31'h0, id_valid}, 32'h0);
        14: begin
          chk("mm_valid", {31'h0, id_valid}, 32'h1);
          chk("mm_word", id_word, 32'h1234_5678);
          chk("mm_retry", {28'h0, retry_cnt}, 32'h2);
        end
        default: ;
      endcase
    end

    // request raised during settle is held off, then reset lands in SERVE
    mask_rev = 32'hA5C3_0F12;
    @(negedge clk);
    do_reset();
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) begin
        addr1 = 2'd3;
        req   = 2'b10;
      end
      if (e < 11 && ack != 2'b00) chk("holdoff_ack", {30'h0, ack}, 32'h0);
      if (e == 10) chk("holdoff_valid", {31'h0, id_valid}, 32'h1);
      if (e == 11) begin
        chk("holdoff_serve", {30'h0, ack}, 32'h2);
        chk("holdoff_rdata", {24'h0, rdata}, 32'hA5);
      end
    end
    resetn = 1'b0;
    req    = 2'b00;
    #1;
    chk("abort_ack", {30'h0, ack}, 32'h0);
    chk("abort_valid", {31'h0, id_valid}, 32'h0);
    chk("abort_word", id_word, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    capture_check(10, 32'hA5C3_0F12, 4'd0);

    repeat (4) @(negedge clk);
    chk("sb_final", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
